// File: rtl/immgen_pkg.sv
// Shared types for the Otter immediate-generation stage: format codes, opcodes and the
// buffered entry layout. Immediates are stored at the widest XLEN and truncated by the user.
package immgen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    logic [31:0]          instr;
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_t             fmt;
    logic                 illegal;
  } imm_entry_t;

  // 32-bit sign-extended immediate for the sign-extending formats; zero for the rest.
  function automatic logic [31:0] raw_imm(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] r;
    r = '0;
    case (fmt)
      FMT_I:   r = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:   r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   r = {instr[31:12], 12'h000};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/immed_gen_pipe_imm_decode.sv
// Combinational opcode decode to {imm, fmt, illegal}.
// IMMGEN_ZICSR_EN: CSR immediate forms (funct3[2]=1) yield FMT_Z with a zero-extended zimm.
module imm_decode
  import immgen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit RV64_EN = 1'b0
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
      OPC_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
        fmt = instr[14] ? FMT_Z : FMT_I;
`else
        fmt = FMT_I;
`endif
      end
      OPC_STORE:  fmt = FMT_S;
      OPC_BRANCH: fmt = FMT_B;
      OPC_OP:     fmt = FMT_NONE;
      OPC_OP_IMM_32: begin
        if (RV64_EN) fmt = FMT_I;
        else         illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // The signed cast makes the widening copy bit 31 into the upper half when XLEN=64.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_NONE: imm = '0;
      FMT_Z:    imm = XLEN'(instr[19:15]);
      default:  imm = XLEN'(signed'(raw_imm(instr, fmt)));
    endcase
  end

endmodule

// File: rtl/immed_gen_pipe.sv
// Registered immediate-generation stage with a 2-entry (output + skid) buffer so in_ready
// is a pure flop. Optional macro IMMGEN_ZICSR_EN is handled inside imm_decode.
module immed_gen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit RV64_EN = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  imm_entry_t      dec_entry;

  imm_entry_t out_q;
  imm_entry_t skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;
  logic       in_ready_q;
  logic       accept;

  imm_decode #(
    .XLEN    (XLEN),
    .RV64_EN (RV64_EN)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec_entry                = '0;
    dec_entry.instr          = in_instr;
    dec_entry.imm[XLEN-1:0]  = dec_imm;
    dec_entry.fmt            = dec_fmt;
    dec_entry.illegal        = dec_illegal;
  end

  assign accept = in_valid && in_ready_q;

  // Skid only fills while the output is stalled, and in_ready is low whenever it is full,
  // so an accept and a skid-to-output move never coincide.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else if (accept) begin
        out_q       <= dec_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec_entry;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_q.instr;
  assign out_imm     = XLEN'(out_q.imm);
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Scoreboard bench for immed_gen_pipe: a 32-bit instance checked through an expected queue,
// plus a 64-bit RV64 instance checked directly.
module tb_immed_gen_pipe;
  import immgen_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  imm_fmt_t    out_fmt;
  logic        out_illegal;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_instr64 = '0;
  logic        out_valid64;
  logic [31:0] out_instr64;
  logic [63:0] out_imm64;
  imm_fmt_t    out_fmt64;
  logic        out_illegal64;

  immed_gen_pipe #(.XLEN(32), .RV64_EN(1'b0)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  immed_gen_pipe #(.XLEN(64), .RV64_EN(1'b1)) dut64 (
    .CLK(CLK), .RST(RST), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
    .out_valid(out_valid64), .out_ready(1'b1), .out_instr(out_instr64),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    imm_fmt_t    fmt;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Reference decode built straight from the opcode table and bit layouts.
  function automatic exp_t model(input logic [31:0] ins, input bit rv64);
    exp_t        e;
    logic [31:0] raw;
    e.instr = ins; e.fmt = FMT_NONE; e.illegal = 1'b0; e.imm = '0; raw = '0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin e.fmt = FMT_U; raw = {ins[31:12], 12'h000}; end
      7'b1101111: begin
        e.fmt = FMT_J;
        raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin e.fmt = FMT_I; raw = {{20{ins[31]}}, ins[31:20]}; end
      7'b1110011: begin
`ifdef IMMGEN_ZICSR_EN
        if (ins[14]) e.fmt = FMT_Z;
        else begin e.fmt = FMT_I; raw = {{20{ins[31]}}, ins[31:20]}; end
`else
        e.fmt = FMT_I; raw = {{20{ins[31]}}, ins[31:20]};
`endif
      end
      7'b0100011: begin e.fmt = FMT_S; raw = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b1100011: begin
        e.fmt = FMT_B;
        raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110011: e.fmt = FMT_NONE;
      7'b0011011: begin
        if (rv64) begin e.fmt = FMT_I; raw = {{20{ins[31]}}, ins[31:20]}; end
        else e.illegal = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.fmt == FMT_Z) e.imm = {59'b0, ins[19:15]};
    else                e.imm = {{32{raw[31]}}, raw};
    return e;
  endfunction

  // Scoreboard: pop and compare on every output transfer, push on every input transfer.
  always @(negedge CLK) begin
    exp_t        e;
    logic [31:0] eimm;
    if (RST || flush) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        n_compared++;
        if (sb.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL scoreboard_unexpected: got instr=%h with queue empty, required no output", out_instr);
        end else begin
          e = sb.pop_front();
          eimm = e.imm[31:0];
          if (out_instr !== e.instr || out_imm !== eimm || out_fmt !== e.fmt || out_illegal !== e.illegal) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard: got instr=%h imm=%h fmt=%0d ill=%0b, required instr=%h imm=%h fmt=%0d ill=%0b",
                     out_instr, out_imm, out_fmt, out_illegal, e.instr, eimm, e.fmt, e.illegal);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) sb.push_back(model(in_instr, 1'b0));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      in_valid = 1'b0; out_ready = 1'b1; in_valid64 = 1'b0;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_compared += 6;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    if (out_imm !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_imm: got %h required 0", out_imm); end
    if (out_fmt !== FMT_NONE) begin n_mismatched++; $display("[TB] FAIL reset_out_fmt: got %0d required 0", out_fmt); end
    if (out_illegal !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_illegal: got %b required 0", out_illegal); end
    if (out_instr !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_out_instr: got %h required 0", out_instr); end
    RST = 1'b0;
    idle(1);
  endtask

  task automatic test_addi;
    @(posedge CLK); #1;
    in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n_compared += 4;
    if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL addi_valid: got %b required 1", out_valid); end
    if (out_imm !== 32'hFFFFFFFF) begin n_mismatched++; $display("[TB] FAIL addi_imm: got %h required ffffffff", out_imm); end
    if (out_fmt !== FMT_I) begin n_mismatched++; $display("[TB] FAIL addi_fmt: got %0d required 1", out_fmt); end
    if (out_illegal !== 1'b0) begin n_mismatched++; $display("[TB] FAIL addi_illegal: got %b required 0", out_illegal); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [31:0] instrs [3];
    logic [31:0] imms   [3];
    instrs = '{32'hFE000EE3, 32'h0010006F, 32'h123450B7};
    imms   = '{32'hFFFFFFFC, 32'h00000800, 32'h12345000};
    out_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      @(posedge CLK); #1;
      if (i > 0) begin
        n_compared++;
        if (out_valid !== 1'b1 || out_imm !== imms[i-1]) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_%0d: got valid=%b imm=%h required valid=1 imm=%h", i-1, out_valid, out_imm, imms[i-1]);
        end
      end
      if (i < 3) begin in_valid = 1'b1; in_instr = instrs[i]; end
      else in_valid = 1'b0;
    end
    idle(2);
  endtask

  task automatic test_stall;
    logic [31:0] cap_instr;
    logic [31:0] cap_imm;
    @(posedge CLK); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00112623;
    @(posedge CLK); #1;
    in_instr = 32'h00000033;
    @(posedge CLK); #1;
    in_instr = 32'hFE000EE3;
    cap_instr = out_instr; cap_imm = out_imm;
    n_compared += 2;
    if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_in_ready: got %b required 0", in_ready); end
    if (out_instr !== 32'h00112623 || out_imm !== 32'h0000000C) begin
      n_mismatched++;
      $display("[TB] FAIL stall_head: got instr=%h imm=%h required instr=00112623 imm=0000000c", out_instr, out_imm);
    end
    @(posedge CLK); #1;
    n_compared += 2;
    if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_in_ready_hold: got %b required 0", in_ready); end
    if (out_valid !== 1'b1 || out_instr !== cap_instr || out_imm !== cap_imm) begin
      n_mismatched++;
      $display("[TB] FAIL stall_stable: got valid=%b instr=%h imm=%h required valid=1 instr=%h imm=%h",
               out_valid, out_instr, out_imm, cap_instr, cap_imm);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    n_compared += 2;
    if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_in_ready: got %b required 1", in_ready); end
    if (out_instr !== 32'h00000033 || out_fmt !== FMT_NONE) begin
      n_mismatched++;
      $display("[TB] FAIL drain_skid: got instr=%h fmt=%0d required instr=00000033 fmt=0", out_instr, out_fmt);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n_compared++;
    if (out_instr !== 32'hFE000EE3) begin n_mismatched++; $display("[TB] FAIL drain_third: got %h required fe000ee3", out_instr); end
    idle(2);
  endtask

  task automatic test_flush(input bit use_rst);
    @(posedge CLK); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00112623;
    @(posedge CLK); #1;
    in_instr = 32'hFE000EE3;
    @(posedge CLK); #1;
    n_compared++;
    if (in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_full_%0d: in_ready got %b required 0", use_rst, in_ready); end
    in_instr = 32'h123450B7;
    if (use_rst) RST = 1'b1; else flush = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_compared += 4;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_valid_%0d: got %b required 0", use_rst, out_valid); end
    if (in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_ready_%0d: got %b required 1", use_rst, in_ready); end
    if (out_imm !== 32'h0) begin n_mismatched++; $display("[TB] FAIL flush_imm_%0d: got %h required 0", use_rst, out_imm); end
    if (out_fmt !== FMT_NONE) begin n_mismatched++; $display("[TB] FAIL flush_fmt_%0d: got %0d required 0", use_rst, out_fmt); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    n_compared++;
    if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_discard_%0d: got valid %b required 0", use_rst, out_valid); end
    idle(1);
  endtask

  task automatic test_illegal;
    logic [31:0] instrs [2];
    instrs = '{32'h0000007F, 32'hFFF0009B};
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1; in_instr = instrs[i];
      @(posedge CLK); #1;
      in_valid = 1'b0;
      n_compared++;
      if (out_illegal !== 1'b1 || out_fmt !== FMT_NONE || out_imm !== 32'h0) begin
        n_mismatched++;
        $display("[TB] FAIL illegal_%h: got ill=%b fmt=%0d imm=%h required ill=1 fmt=0 imm=0", instrs[i], out_illegal, out_fmt, out_imm);
      end
    end
    idle(1);
  endtask

  task automatic test_zicsr;
    imm_fmt_t    efmt;
    logic [31:0] eimm;
`ifdef IMMGEN_ZICSR_EN
    efmt = FMT_Z; eimm = 32'h00000001;
`else
    efmt = FMT_I; eimm = 32'h00000340;
`endif
    @(posedge CLK); #1;
    in_valid = 1'b1; in_instr = 32'h3400D073;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n_compared++;
    if (out_fmt !== efmt || out_imm !== eimm) begin
      n_mismatched++;
      $display("[TB] FAIL zicsr: got fmt=%0d imm=%h required fmt=%0d imm=%h", out_fmt, out_imm, efmt, eimm);
    end
    idle(1);
  endtask

  task automatic test_rv64;
    @(posedge CLK); #1;
    in_valid64 = 1'b1; in_instr64 = 32'h800000B7;
    @(posedge CLK); #1;
    in_instr64 = 32'hFFF0009B;
    n_compared++;
    if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFF80000000 || out_fmt64 !== FMT_U) begin
      n_mismatched++;
      $display("[TB] FAIL rv64_lui: got valid=%b imm=%h fmt=%0d required valid=1 imm=ffffffff80000000 fmt=4",
               out_valid64, out_imm64, out_fmt64);
    end
    @(posedge CLK); #1;
    in_valid64 = 1'b0;
    n_compared++;
    if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF || out_fmt64 !== FMT_I || out_illegal64 !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rv64_addiw: got imm=%h fmt=%0d ill=%b required imm=ffffffffffffffff fmt=1 ill=0",
               out_imm64, out_fmt64, out_illegal64);
    end
    idle(1);
  endtask

  task automatic test_random;
    logic [6:0]  ops [12];
    logic [31:0] r;
    logic        was_acc;
    int          budget;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b1110011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0011011, 7'b1111111};
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      was_acc = in_valid && in_ready;
      @(posedge CLK); #1;
      if (!in_valid || was_acc) begin
        r = $urandom();
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = {r[31:7], ops[$urandom_range(0, 11)]};
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge CLK); #1;
      budget++;
    end
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL random_drain: got %0d entries outstanding required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_illegal();
    test_zicsr();
    test_rv64();
    test_random();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
